// File: rtl/sobel_stream_5x5.sv
// sobel_stream_5x5: streaming 5x5 Sobel edge filter over a raster pixel stream.
//
// Builds the 5x5 window from four line buffers plus a 5x5 shift register and emits
// one filtered pixel per accepted input, centred two rows and two columns behind it.
// A single enable (en = !m_valid || m_ready) advances the whole 3-stage pipeline.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode[1:0]           0=|Gy|, 1=|Gx|, 2=(|Gx|+|Gy|)>>1, 3=same as 0; latched at (0,0)
//   s_valid/s_ready     input handshake; s_data pixel, s_sof first pixel of frame
//   m_valid/m_ready     output handshake; m_data result, m_sof first, m_eol line end
module sobel_stream_5x5 #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol
);
    localparam int unsigned ACC_W = PIX_W + 7;
    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);

    // Sobel 5x5 is separable: derivative [-1 -2 0 2 1] times smoothing [1 4 6 4 1].
    localparam int KD [5] = '{-1, -2, 0, 2, 1};
    localparam int KS [5] = '{1, 4, 6, 4, 1};

    logic                    w_en;
    logic                    w_acc;
    logic [CW-1:0]           w_col;
    logic [RW-1:0]           w_row;
    logic                    w_origin;
    logic                    w_col_last;
    logic                    w_row_last;
    logic [1:0]              w_mode_in;
    logic [PIX_W-1:0]        w_newcol [5];
    logic signed [ACC_W-1:0] w_gx;
    logic signed [ACC_W-1:0] w_gy;
    logic [ACC_W-1:0]        w_ax;
    logic [ACC_W-1:0]        w_ay;
    logic [ACC_W:0]          w_sel;
    logic [PIX_W-1:0]        w_pix;

    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [1:0]              r_mode;
    logic [PIX_W-1:0]        r_lb [4][IMG_W];
    logic [PIX_W-1:0]        r_win [5][5];
    logic                    r_v1, r_sof1, r_eol1, r_bord1;
    logic [1:0]              r_mode1;
    logic                    r_v2, r_sof2, r_eol2, r_bord2;
    logic [1:0]              r_mode2;
    logic signed [ACC_W-1:0] r_gx;
    logic signed [ACC_W-1:0] r_gy;

    assign w_en       = !m_valid || m_ready;
    assign s_ready    = w_en;
    assign w_acc      = s_valid && w_en;
    // s_sof overrides whatever the counters say, so a new frame always resyncs.
    assign w_col      = s_sof ? '0 : r_col;
    assign w_row      = s_sof ? '0 : r_row;
    assign w_origin   = (w_col == '0) && (w_row == '0);
    assign w_col_last = (w_col == CW'(IMG_W - 1));
    assign w_row_last = (w_row == RW'(IMG_H - 1));
    assign w_mode_in  = (mode == 2'd3) ? 2'd0 : mode;

    // Newest column of the window: row r from the input, rows r-1..r-4 from line buffers.
    always_comb begin
        w_newcol[4] = s_data;
        w_newcol[3] = r_lb[0][w_col];
        w_newcol[2] = r_lb[1][w_col];
        w_newcol[1] = r_lb[2][w_col];
        w_newcol[0] = r_lb[3][w_col];
    end

    // Window row 0 is the oldest line (r-4), column 0 the oldest pixel (c-4).
    always_comb begin
        int acc_x;
        int acc_y;
        int p;
        acc_x = 0;
        acc_y = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                p     = int'(r_win[i][j]);
                acc_y = acc_y + KD[i] * KS[j] * p;
                acc_x = acc_x + KS[i] * KD[j] * p;
            end
        end
        w_gx = ACC_W'(acc_x);
        w_gy = ACC_W'(acc_y);
    end

    // Magnitude first, then a logical shift, then saturation to the pixel range.
    always_comb begin
        w_ax = r_gx[ACC_W-1] ? -r_gx : r_gx;
        w_ay = r_gy[ACC_W-1] ? -r_gy : r_gy;
        case (r_mode2)
            2'd1:    w_sel = {1'b0, w_ax} >> SHIFT;
            2'd2:    w_sel = ({1'b0, w_ax} + {1'b0, w_ay}) >> (SHIFT + 1);
            default: w_sel = {1'b0, w_ay} >> SHIFT;
        endcase
        if (r_bord2) begin
            w_pix = '0;
        end else if (|w_sel[ACC_W:PIX_W]) begin
            w_pix = '1;
        end else begin
            w_pix = w_sel[PIX_W-1:0];
        end
    end

    // Pixel storage: line buffers cascade one row per stage, window shifts left.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb[0][w_col] <= s_data;
            for (int k = 1; k < 4; k++) begin
                r_lb[k][w_col] <= r_lb[k-1][w_col];
            end
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
                r_win[i][4] <= w_newcol[i];
            end
        end
        if (w_en) begin
            r_gx <= w_gx;
            r_gy <= w_gy;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_mode  <= 2'd0;
            r_v1    <= 1'b0;
            r_sof1  <= 1'b0;
            r_eol1  <= 1'b0;
            r_bord1 <= 1'b1;
            r_mode1 <= 2'd0;
            r_v2    <= 1'b0;
            r_sof2  <= 1'b0;
            r_eol2  <= 1'b0;
            r_bord2 <= 1'b1;
            r_mode2 <= 2'd0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_col <= w_col_last ? '0 : w_col + CW'(1);
                r_row <= w_col_last ? (w_row_last ? '0 : w_row + RW'(1)) : w_row;
                if (w_origin) begin
                    r_mode <= w_mode_in;
                end
            end
            if (w_en) begin
                r_v1 <= s_valid;
                if (s_valid) begin
                    r_sof1  <= w_origin;
                    r_eol1  <= w_col_last;
                    r_bord1 <= (w_row < RW'(4)) || (w_col < CW'(4));
                    // Mode travels with the pixel so frame tails keep their own mode.
                    r_mode1 <= w_origin ? w_mode_in : r_mode;
                end
                r_v2    <= r_v1;
                r_sof2  <= r_sof1;
                r_eol2  <= r_eol1;
                r_bord2 <= r_bord1;
                r_mode2 <= r_mode1;
                m_valid <= r_v2;
                m_data  <= r_v2 ? w_pix : '0;
                m_sof   <= r_v2 && r_sof2;
                m_eol   <= r_v2 && r_eol2;
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream_5x5.sv
// tb_sobel_stream_5x5: directed bench for sobel_stream_5x5 on a small 8x16 frame.
// Expected pixels come from a direct 5x5 convolution with the full kernel tables.
module tb_sobel_stream_5x5;
    localparam int IMG_W = 8;
    localparam int IMG_H = 16;
    localparam int SH    = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    localparam int KY [5][5] = '{'{-1, -4, -6, -4, -1},
                                 '{-2, -8, -12, -8, -2},
                                 '{0, 0, 0, 0, 0},
                                 '{2, 8, 12, 8, 2},
                                 '{1, 4, 6, 4, 1}};

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sof;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_acc    = 0;
    int         last_base = 0;
    logic       stall_en = 1'b0;
    int         img [IMG_H][IMG_W];
    logic [7:0] q_data[$];
    logic       q_sof[$];
    logic       q_eol[$];

    sobel_stream_5x5 #(
        .PIX_W(8),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .SHIFT(SH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_sof  (s_sof),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_sof  (m_sof),
        .m_eol  (m_eol)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_px(input int r, input int c, input int md);
        int gx, gy, ax, ay, v;
        if (r < 4 || c < 4) return 0;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                v  = img[r-4+i][c-4+j];
                gy = gy + KY[i][j] * v;
                gx = gx + KY[j][i] * v;
            end
        end
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (md)
            1:       v = ax >> SH;
            2:       v = (ax + ay) >> (SH + 1);
            default: v = ay >> SH;
        endcase
        return (v > 255) ? 255 : v;
    endfunction

    // m_ready toggles randomly only while stall_en is set.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Output collector; also checks m_data holds while stalled.
    initial begin : collect
        logic       hold;
        logic [7:0] hold_d;
        hold   = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", 32'(m_data), 32'(hold_d));
                end
                if (m_valid && m_ready) begin
                    q_data.push_back(m_data);
                    q_sof.push_back(m_sof);
                    q_eol.push_back(m_eol);
                end
                hold   = m_valid && !m_ready;
                hold_d = m_data;
            end
        end
    end

    task automatic send_px(input int v, input logic sof, input int md);
        logic ok;
        s_valid = 1'b1;
        s_data  = 8'(v);
        s_sof   = sof;
        mode    = 2'(md);
        ok      = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        chk("accept", 32'(ok), 32'd1);
        n_acc++;
    endtask

    task automatic go_idle();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q_data.size() < n_acc && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("drain_count", 32'(q_data.size()), 32'(n_acc));
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input int md);
        for (int k = 0; k < n; k++) begin
            send_px(img[k / IMG_W][k % IMG_W], (k == 0), md);
        end
        go_idle();
    endtask

    task automatic run_frame(input int md_a, input int md_b, input int sw, input int md_exp,
                             input string tag);
        int base, n, nsof, neol;
        base = q_data.size();
        last_base = base;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                send_px(img[r][c], (r == 0 && c == 0), (r < sw) ? md_a : md_b);
            end
        end
        go_idle();
        drain();
        n = q_data.size() - base;
        if (n > NPIX) n = NPIX;
        nsof = 0;
        neol = 0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s data r%0d c%0d", tag, k / IMG_W, k % IMG_W),
                32'(q_data[base+k]), 32'(ref_px(k / IMG_W, k % IMG_W, md_exp)));
            chk($sformatf("%s sof k%0d", tag, k), 32'(q_sof[base+k]), 32'(k == 0));
            chk($sformatf("%s eol k%0d", tag, k), 32'(q_eol[base+k]),
                32'((k % IMG_W) == IMG_W - 1));
            nsof += int'(q_sof[base+k]);
            neol += int'(q_eol[base+k]);
        end
        chk({tag, " count"}, 32'(q_data.size() - base), 32'(NPIX));
        chk({tag, " sof_count"}, 32'(nsof), 32'd1);
        chk({tag, " eol_count"}, 32'(neol), 32'(IMG_H));
    endtask

    function automatic int out_at(input int r, input int c);
        int idx;
        idx = last_base + r * IMG_W + c;
        return (idx < q_data.size()) ? int'(q_data[idx]) : -1;
    endfunction

    task automatic fill_const(input int v);
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++) img[r][c] = v;
    endtask

    task automatic fill_step(input int row, input int v);
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++)
            img[r][c] = (r < row) ? 0 : v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < IMG_H; r++) for (int c = 0; c < IMG_W; c++)
            img[r][c] = int'($urandom_range(0, 255));
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        mode    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("rst m_sof", 32'(m_sof), 32'd0);
        chk("rst m_eol", 32'(m_eol), 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("rst s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Flat image: no gradient in any direction.
        fill_const(77);
        run_frame(0, 0, 0, 0, "const_m0");
        chk("const_m0 hand r8c5", 32'(out_at(8, 5)), 32'd0);
        run_frame(1, 1, 0, 1, "const_m1");
        chk("const_m1 hand r15c7", 32'(out_at(15, 7)), 32'd0);

        // Horizontal step 0 -> 20 at row 10.
        fill_step(10, 20);
        run_frame(0, 0, 0, 0, "step20_m0");
        chk("step20 r10 bottom_row", 32'(out_at(10, 5)), 32'd20);
        chk("step20 r11 two_rows", 32'(out_at(11, 5)), 32'd60);
        chk("step20 r12 top2_zero", 32'(out_at(12, 5)), 32'd60);
        chk("step20 r13 top_zero", 32'(out_at(13, 5)), 32'd20);
        chk("step20 r14 full", 32'(out_at(14, 5)), 32'd0);
        run_frame(1, 1, 0, 1, "step20_m1");
        chk("step20_m1 r12", 32'(out_at(12, 6)), 32'd0);

        // Step 100: saturation in mode 0, halved sum in mode 2.
        fill_step(10, 100);
        run_frame(0, 0, 0, 0, "step100_m0");
        chk("step100 r10", 32'(out_at(10, 4)), 32'd100);
        chk("step100 r11 sat", 32'(out_at(11, 4)), 32'd255);
        chk("step100 r12 sat", 32'(out_at(12, 7)), 32'd255);
        run_frame(2, 2, 0, 2, "step100_m2");
        chk("step100_m2 r10", 32'(out_at(10, 4)), 32'd50);
        chk("step100_m2 r11", 32'(out_at(11, 4)), 32'd150);

        // Random image with backpressure.
        fill_rand();
        stall_en = 1'b1;
        run_frame(2, 2, 0, 2, "stall_m2");
        stall_en = 1'b0;
        @(posedge clk);
        #1;

        // Mode change mid-frame only takes effect next frame; mode 3 behaves as 0.
        fill_rand();
        run_frame(0, 1, 8, 0, "switch_mid");
        run_frame(1, 1, 0, 1, "gx_next");
        run_frame(3, 3, 0, 0, "mode3");

        // Partial frame, then s_sof resynchronises the counters.
        send_n(20, 1);
        drain();
        run_frame(0, 0, 0, 0, "sof_resync");

        // Asynchronous reset in the middle of a frame.
        fill_rand();
        send_n(8 * IMG_W, 0);
        chk("pre_rst m_valid", 32'(m_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async m_valid", 32'(m_valid), 32'd0);
        chk("async m_data", 32'(m_data), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        q_data.delete();
        q_sof.delete();
        q_eol.delete();
        n_acc = 0;
        @(posedge clk);
        #1;
        fill_rand();
        run_frame(0, 0, 0, 0, "after_rst");
        chk("after_rst r3c6", 32'(out_at(3, 6)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sobel_stream_5x5.md
Name: sobel_stream_5x5

Overview:
Streaming 5x5 Sobel edge filter and the parametrised successor of the combinational single-window Y filter. It accepts a raster pixel stream, builds the 5x5 window internally from four line buffers, and computes Gx, Gy or |Gx|+|Gy| per pixel. Output uses valid/ready with full backpressure. It sits between the IDCT/colour-conversion output stage and the frame writer in the filter chain.

Parameters:
PIX_W, 8, pixel width in bits (input and output)
IMG_W, 640, frame width in pixels (>=5)
IMG_H, 480, frame height in lines (>=5)
SHIFT, 4, right shift applied to the absolute gradient before saturation

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  2  0=|Gy|, 1=|Gx|, 2=(|Gx|+|Gy|)>>1, 3=reserved (treated as 0)
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&&s_ready
s_data  in  PIX_W  input pixel, raster order
s_sof  in  1  marks first pixel of a frame; resynchronises counters
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_data  out  PIX_W  filtered pixel
m_sof  out  1  first output of frame
m_eol  out  1  last output of a line

Behaviour:
- Reset (async, rst_n=0): m_valid=0, m_data=0, m_sof=0, m_eol=0, row/col counters=0, latched mode=0, pipeline valid bits=0. Line-buffer contents need no reset. s_ready=1 once rst_n deasserts.
- Global pipeline enable: en = !m_valid || m_ready. s_ready = en. When en=0 the pipeline holds all stages and m_data stays stable.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1. Both advance on each accepted pixel. col wraps to 0 and increments row. row wraps to 0 after the last pixel of a frame.
- An accepted pixel with s_sof=1 forces col=row=0 for that pixel, irrespective of the counter values. No error is flagged.
- Mode is latched on the accepted pixel at row=0,col=0. A mode change mid-frame has no effect until the next frame.
- Window: for the input pixel at (r,c), the window spans rows r-4..r and cols c-4..c. The output is the filter result centred at (r-2,c-2). The block emits exactly one output per accepted input.
- Border: if r<4 or c<4, the output is 0. Window rows come from four line buffers of depth IMG_W plus a 5x5 shift register.
- Kernel, Gy rows top to bottom:
  - [-1 -4 -6 -4 -1]
  - [-2 -8 -12 -8 -2]
  - [0 0 0 0 0]
  - [2 8 12 8 2]
  - [1 4 6 4 1]
  Gx is the transpose (left columns negative).
- Arithmetic: signed accumulators of PIX_W+7 bits, with no intermediate wrap. Absolute value is taken before the shift; the shift is logical on the magnitude. Mode 2 sums |Gx|+|Gy| in PIX_W+8 bits, then shifts by SHIFT+1. The result saturates to 2^PIX_W-1.
- Latency: 3 enabled cycles from input accept to m_valid (stage 1 window/partial products, stage 2 column sums, stage 3 abs/shift/saturate).
- m_sof/m_eol travel with the pixel through the pipeline: m_sof for (0,0), m_eol for col=IMG_W-1.
- Reset mid-frame: the pipeline is flushed and no stale outputs appear. The next frame must start with s_sof or at counter (0,0). Rows from before the reset are treated as border (output 0 until 4 new rows have been received).
- Simultaneous s_sof and the counter already at (0,0): identical behaviour.

Test Plan:
- Constant frame, all pixels 77, mode 0 and 1 -> every output 0. Output count = IMG_W*IMG_H. m_sof asserts once and m_eol asserts IMG_H times.
- Mode 0 horizontal step: rows <10 = 0, rows >=10 = 20. Window with only its top row 0 -> 20. Window with top two rows 0 (centre row 20) -> 60. Window fully 20 -> 0. Same image in mode 1 -> all 0.
- Mode 0 with step value 100 -> Gy=4800, 4800>>4=300, saturates to 255. Mode 2 on the same image -> (4800+0)>>5=150.
- Random m_ready (~50% duty) over a random image -> output sequence identical to the no-stall run. m_data stays stable while m_valid && !m_ready.
- mode switched from 0 to 1 at row 100 -> whole frame is still computed as Gy. Next frame is computed as Gx. mode=3 -> identical to mode 0.
- rst_n pulsed low at row 50 -> m_valid=0 immediately (async). After restart with s_sof, outputs match a clean run, including 0 for rows 0-3.
